axi_stream_strip_header: RTL
============================

AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), width of the header length field.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL have the input stream ports: valid_in in 1; data_in in DATA_WD; keep_in in DATA_BYTE_WD; last_in in 1; ready_in out 1.
REQ-006 SHALL have the payload output ports: valid_out out 1; data_out out DATA_WD; keep_out out DATA_BYTE_WD; last_out out 1; ready_out in 1.
REQ-007 SHALL have the header output ports: valid_header out 1; data_header out DATA_WD; keep_header out DATA_BYTE_WD; ready_header in 1.
REQ-008 SHALL have byte_strip_cnt  in  BYTE_CNT_WD, giving header length H = byte_strip_cnt+1 bytes (1..DATA_BYTE_WD); err_short  out  1  short-packet pulse.

Function
REQ-009 SHALL order bytes MSB-first (byte 0 = data[DATA_WD-1:DATA_WD-8]); keep_in/keep_out SHALL be MSB-contiguous; non-last beats SHALL be full.
REQ-010 SHALL sample H on the first accepted beat of each packet and hold it until that packet's last output beat.
REQ-011 SHALL use FSM states IDLE (awaiting first beat), STREAM (mid-packet), FLUSH (residual after last_in); IDLE->STREAM on non-last first beat; STREAM->FLUSH on last beat with k>H valid bytes; STREAM->IDLE on last beat with k<=H; FLUSH->IDLE when the flush beat is accepted.
REQ-012 SHALL place the first H bytes of the packet right-aligned in data_header, with keep_header equal to the low H bits set and the remaining bits zero, valid_header asserted one cycle after acceptance and held until ready_header.
REQ-013 SHALL hold the remaining DATA_BYTE_WD-H bytes of each beat as a residual, and emit {residual, top H bytes of the next beat} as each output beat.
REQ-014 SHALL emit, on a last beat with k<=H, one beat with last_out=1 and keep_out of (DATA_BYTE_WD-H+k) MSB ones; with k>H, a full beat followed by a FLUSH beat of k-H bytes with last_out=1.
REQ-015 SHALL, on a single-beat packet with k>H, emit one FLUSH beat of k-H bytes; with k==H, emit no payload beat.
REQ-016 SHALL register all outputs, with 1-cycle latency from accepting an input to the corresponding output.
REQ-017 SHALL drive ready_in = 1 in IDLE when the header slot is empty or being drained that cycle; in STREAM when !valid_out | ready_out; and 0 in FLUSH.
REQ-018 SHALL hold data_out/keep_out/last_out stable while valid_out && !ready_out, and likewise the header outputs while valid_header && !ready_header.
REQ-019 SHALL accept the next packet's first beat in the same cycle as the FLUSH beat is accepted only if the header slot is free; no bytes are lost or duplicated under any backpressure.

Reset
REQ-020 SHALL, on rst_n low, immediately clear valid_out, valid_header, last_out, err_short, data/keep outputs and residual to 0, and set the FSM to IDLE; ready_in SHALL be 0 during reset.
REQ-021 SHALL, on reset mid-packet, discard the partial packet; the first beat after release SHALL be treated as a new packet's header.

Configuration
REQ-022 With macro AXIS_STRIP_SHORT_ERR_EN defined, err_short SHALL pulse high for one cycle when a single-beat packet has k<H, and keep_header SHALL then contain the low k bits set.
REQ-023 Without AXIS_STRIP_SHORT_ERR_EN, err_short SHALL be tied to 0, and the short header SHALL be emitted with keep_header of H bits; short-packet logic is absent.

Verification
REQ-024 H=1 (cnt=0): 11223344, 55667788, 99AABBCC(last, keep F) -> header 00000011 keep 0001; outputs 22334455, 66778899, AABBCCxx keep 1110 last.
REQ-025 H=4 (cnt=3): A0A1A2A3, B0B1B2B3(last, keep 1100) -> header A0A1A2A3 keep 1111; one output B0B1xxxx keep 1100 last.
REQ-026 H=2 (cnt=1): 01020304, 05060708(last, keep 1000) -> header 00000102 keep 0011; one output 030405xx keep 1110 last.
REQ-027 H=3: ready_out low for 5 cycles mid-packet -> data_out stable, ready_in 0, ready_header low delays the next packet only; full byte sequence intact.
REQ-028 H=3, single beat DEADBEEF(last, keep 1100) -> header 0000DEAD with keep 0011 and err_short one pulse (macro on); without the macro, keep 0111 and err_short 0; no payload beat in either case.
REQ-029 Assert rst_n low mid-packet -> all valids 0 immediately; the next packet strips correctly.

Source files
------------

// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: removes an H-byte header from each AXI-stream packet.
// Optional feature macro AXIS_STRIP_SHORT_ERR_EN flags single-beat short packets.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    err_short
);

    localparam int HW = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t             state;
    logic [HW-1:0]      h_reg;
    logic [HW-1:0]      flush_cnt;
    logic [DATA_WD-1:0] residual;

    int                 h_new;
    int                 h_cur;
    int                 hdr_len;
    int                 k;
    logic               accept;
    logic [DATA_WD-1:0] stream_word;
    logic [DATA_WD-1:0] res_next;
`ifdef AXIS_STRIP_SHORT_ERR_EN
    logic               short_pkt;
`endif

    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input int n);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (i < n) m[DATA_BYTE_WD-1-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] lsb_ones(input int n);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] low_bytes(input int n);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (i < n) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Handshake, header length and byte-realignment datapath.
    always_comb begin
        h_new = 32'(byte_strip_cnt) + 1;
        h_cur = (state == IDLE) ? h_new : 32'(h_reg);
        k = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (keep_in[i]) k = k + 1;
        hdr_len = h_new;
`ifdef AXIS_STRIP_SHORT_ERR_EN
        short_pkt = 1'b0;
        if (last_in && (k < h_new)) begin
            hdr_len   = k;
            short_pkt = 1'b1;
        end
`endif
        ready_in = 1'b0;
        unique case (state)
            IDLE:    ready_in = !valid_header || ready_header;
            STREAM:  ready_in = !valid_out || ready_out;
            default: ready_in = 1'b0;
        endcase
        if (!rst_n) ready_in = 1'b0;
        accept = valid_in && ready_in;
        stream_word = (residual << (8 * h_cur))
                    | (data_in >> (8 * (DATA_BYTE_WD - h_cur)));
        res_next = data_in & low_bytes(DATA_BYTE_WD - h_cur);
    end

    // Packet FSM with registered header and payload outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            h_reg        <= '0;
            flush_cnt    <= '0;
            residual     <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
`ifdef AXIS_STRIP_SHORT_ERR_EN
            err_short    <= 1'b0;
`endif
        end else begin
`ifdef AXIS_STRIP_SHORT_ERR_EN
            err_short <= 1'b0;
`endif
            if (valid_out && ready_out) valid_out <= 1'b0;
            if (valid_header && ready_header) valid_header <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        h_reg        <= HW'(h_new);
                        valid_header <= 1'b1;
                        data_header  <= data_in >> (8 * (DATA_BYTE_WD - hdr_len));
                        keep_header  <= lsb_ones(hdr_len);
                        residual     <= res_next;
`ifdef AXIS_STRIP_SHORT_ERR_EN
                        err_short    <= short_pkt;
`endif
                        if (!last_in) begin
                            state <= STREAM;
                        end else if (k > h_new) begin
                            flush_cnt <= HW'(k - h_new);
                            state     <= FLUSH;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        valid_out <= 1'b1;
                        data_out  <= stream_word;
                        residual  <= res_next;
                        if (!last_in) begin
                            keep_out <= '1;
                            last_out <= 1'b0;
                        end else if (k > h_cur) begin
                            keep_out  <= '1;
                            last_out  <= 1'b0;
                            flush_cnt <= HW'(k - h_cur);
                            state     <= FLUSH;
                        end else begin
                            keep_out <= msb_ones(DATA_BYTE_WD - h_cur + k);
                            last_out <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (!valid_out || ready_out) begin
                        valid_out <= 1'b1;
                        data_out  <= residual << (8 * h_cur);
                        keep_out  <= msb_ones(32'(flush_cnt));
                        last_out  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef AXIS_STRIP_SHORT_ERR_EN
    assign err_short = 1'b0;
`endif

endmodule
